// File: rtl/ej32_pkg.sv
// Shared eJ32 definitions: opcode encodings and the return-stack op set.
package ej32_pkg;

   localparam int RS_DEPTH_DEF = 16;

   typedef enum logic [7:0] {
      OP_NOP      = 8'h00,
      OP_ILOAD    = 8'h15,
      OP_ILOAD_0  = 8'h1a,
      OP_ILOAD_1  = 8'h1b,
      OP_ILOAD_2  = 8'h1c,
      OP_ILOAD_3  = 8'h1d,
      OP_ISTORE_0 = 8'h3b,
      OP_JSR      = 8'ha8,
      OP_RET      = 8'ha9,
      OP_PUSHR    = 8'hd2,
      OP_POPR     = 8'hd3,
      OP_DUPR     = 8'hd4
   } opcode_t;

   typedef enum logic [2:0] {
      rNOP,
      rPUSH,
      rPOP,
      rPEEK,
      rSET
   } rs_op_t;

endpackage

// File: rtl/rs_decode.sv
// Maps opcode/phase to a return-stack op, the value it carries and the peek depth.
module rs_decode
   import ej32_pkg::*;
#(
   parameter int DSZ = 32,
   parameter int ASZ = 16
) (
   input  logic [7:0]     code,
   input  logic [2:0]     phase,
   input  logic [DSZ-1:0] t,
   input  logic [ASZ-1:0] pc,
   output rs_op_t         op_o,
   output logic [DSZ-1:0] val_o,
   output logic [1:0]     idx_o
);

   always_comb begin
      op_o  = rNOP;
      val_o = t;
      idx_o = 2'd0;
      case (code)
         OP_PUSHR:    if (phase == 3'd0) op_o = rPUSH;
         OP_JSR: begin
            if (phase == 3'd2) op_o = rPUSH;
            val_o = {{(DSZ-ASZ){1'b0}}, pc};
         end
         OP_POPR,
         OP_RET:      if (phase == 3'd0) op_o = rPOP;
         OP_DUPR:     if (phase == 3'd0) op_o = rPEEK;
         OP_ILOAD_0:  if (phase == 3'd0) op_o = rPEEK;
         OP_ILOAD_1: begin
            if (phase == 3'd0) op_o = rPEEK;
            idx_o = 2'd1;
         end
         OP_ILOAD_2: begin
            if (phase == 3'd0) op_o = rPEEK;
            idx_o = 2'd2;
         end
         OP_ILOAD_3: begin
            if (phase == 3'd0) op_o = rPEEK;
            idx_o = 2'd3;
         end
         // Indexed load takes its depth from the low bits of TOS.
         OP_ILOAD: begin
            if (phase == 3'd1) op_o = rPEEK;
            idx_o = t[1:0];
         end
         OP_ISTORE_0: if (phase == 3'd0) op_o = rSET;
         default:     op_o = rNOP;
      endcase
   end

endmodule

// File: rtl/ej32_rs.sv
// eJ32 return stack: cached top register r plus an async-read array for deeper entries.
module ej32_rs
   import ej32_pkg::*;
#(
   parameter int RS_DEPTH = RS_DEPTH_DEF,
   parameter int DSZ      = 32,
   parameter int ASZ      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rs_en,
   input  logic [7:0]                  code,
   input  logic [2:0]                  phase,
   input  logic [DSZ-1:0]              t,
   input  logic [ASZ-1:0]              pc,
   output logic [DSZ-1:0]              rs_o,
   output logic [$clog2(RS_DEPTH):0]   rp_o,
   output logic                        ovf_o,
   output logic                        unf_o
);

   localparam int AW  = $clog2(RS_DEPTH);
   localparam int RPW = AW + 1;
   localparam logic [RPW-1:0] FULL = RPW'(RS_DEPTH);

   rs_op_t         op;
   logic [DSZ-1:0] val;
   logic [1:0]     idx;

   logic [RPW-1:0] rp_q, rp_d;
   logic [DSZ-1:0] r_q, r_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;
   logic           mem_we;
   logic [DSZ-1:0] mem [RS_DEPTH-1];

   logic [RPW-1:0] peek_k;
   logic [AW-1:0]  wr_idx, pop_idx, peek_idx;

   rs_decode #(.DSZ(DSZ), .ASZ(ASZ)) u_decode (
      .code  (code),
      .phase (phase),
      .t     (t),
      .pc    (pc),
      .op_o  (op),
      .val_o (val),
      .idx_o (idx)
   );

   // mem[i] holds entry i+1, so entry n lives at mem[n-1].
   assign peek_k   = RPW'(idx);
   assign wr_idx   = AW'(rp_q - RPW'(1));
   assign pop_idx  = AW'(rp_q - RPW'(2));
   assign peek_idx = AW'(rp_q - RPW'(1) - peek_k);

   always_comb begin
      rp_d   = rp_q;
      r_d    = r_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      mem_we = 1'b0;
      rs_o   = r_q;
      case (op)
         rPUSH: begin
            if (rp_q == FULL) begin
               ovf_d = 1'b1;
            end else begin
               mem_we = (rp_q != '0);
               r_d    = val;
               rp_d   = rp_q + RPW'(1);
            end
         end
         rPOP: begin
            if (rp_q == '0) begin
               rs_o  = '0;
               unf_d = 1'b1;
            end else begin
               rs_o = r_q;
               rp_d = rp_q - RPW'(1);
               if (rp_q >= RPW'(2)) r_d = mem[pop_idx];
               else                 r_d = '0;
            end
         end
         rPEEK: begin
            if (peek_k >= rp_q) begin
               rs_o  = '0;
               unf_d = 1'b1;
            end else if (idx == 2'd0) begin
               rs_o = r_q;
            end else begin
               rs_o = mem[peek_idx];
            end
         end
         rSET: begin
            if (rp_q == '0) unf_d = 1'b1;
            else            r_d   = val;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rp_q  <= '0;
         r_q   <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (rs_en) begin
         rp_q  <= rp_d;
         r_q   <= r_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Array is never cleared; only entries below rp are meaningful.
   always_ff @(posedge clk) begin
      if (!rst && rs_en && mem_we) mem[wr_idx] <= r_q;
   end

   assign rp_o  = rp_q;
   assign ovf_o = ovf_q;
   assign unf_o = unf_q;

endmodule

// File: tb/tb_ej32_rs.sv
// Self-checking bench for ej32_rs: directed scenarios plus random ops against a queue model.
module tb_ej32_rs;
   import ej32_pkg::*;

   localparam int D   = 4;
   localparam int DSZ = 32;
   localparam int ASZ = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            rs_en;
   logic [7:0]      code;
   logic [2:0]      phase;
   logic [DSZ-1:0]  t;
   logic [ASZ-1:0]  pc;
   logic [DSZ-1:0]  rs_o;
   logic [$clog2(D):0] rp_o;
   logic            ovf_o;
   logic            unf_o;

   int n_checks = 0;
   int n_pass   = 0;
   logic [DSZ-1:0] rs_seen;

   logic [DSZ-1:0] m_stk[$];
   bit m_ovf, m_unf;

   ej32_rs #(.RS_DEPTH(D), .DSZ(DSZ), .ASZ(ASZ)) dut (
      .clk   (clk),
      .rst   (rst),
      .rs_en (rs_en),
      .code  (code),
      .phase (phase),
      .t     (t),
      .pc    (pc),
      .rs_o  (rs_o),
      .rp_o  (rp_o),
      .ovf_o (ovf_o),
      .unf_o (unf_o)
   );

   always #5 clk = ~clk;

   // Apply one op for one cycle; rs_seen holds rs_o sampled before the edge.
   task automatic step(input logic [7:0] c, input logic [2:0] ph, input logic [31:0] tv,
                       input logic [15:0] pv, input bit en, input bit r);
      code = c; phase = ph; t = tv; pc = pv; rs_en = en; rst = r;
      #1 rs_seen = rs_o;
      @(posedge clk);
      #1;
      code = OP_NOP; phase = 3'd0; rs_en = 1'b0; rst = 1'b0;
   endtask

   task automatic do_reset();
      step(OP_NOP, 3'd0, 32'h0, 16'h0, 1'b0, 1'b1);
      m_stk.delete(); m_ovf = 0; m_unf = 0;
   endtask

   task automatic test_reset();
      step(OP_PUSHR, 3'd0, 32'h99, 16'h0, 1'b1, 1'b0);
      do_reset();
      n_checks++;
      if (rp_o !== 3'd0 || ovf_o !== 1'b0 || unf_o !== 1'b0)
         $display("FAIL reset_state rp=%0d ovf=%b unf=%b required rp=0 ovf=0 unf=0", rp_o, ovf_o, unf_o);
      else n_pass++;
   endtask

   task automatic test_push_pop();
      logic [31:0] exp_v [3] = '{32'h33, 32'h22, 32'h11};
      do_reset();
      step(OP_PUSHR, 3'd0, 32'h11, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'h22, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'h33, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rp_o !== 3'd3) $display("FAIL push3_rp got %0d required 3", rp_o);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step(OP_POPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
         n_checks++;
         if (rs_seen !== exp_v[i] || rp_o !== 3'(2 - i))
            $display("FAIL pop_%0d got rs=%h rp=%0d required rs=%h rp=%0d", i, rs_seen, rp_o, exp_v[i], 2 - i);
         else n_pass++;
      end
      n_checks++;
      if (ovf_o !== 1'b0 || unf_o !== 1'b0)
         $display("FAIL push_pop_flags got ovf=%b unf=%b required 0 0", ovf_o, unf_o);
      else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 1; i <= 5; i++) step(OP_PUSHR, 3'd0, 32'(i), 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rp_o !== 3'd4 || ovf_o !== 1'b1 || unf_o !== 1'b0)
         $display("FAIL overflow got rp=%0d ovf=%b unf=%b required rp=4 ovf=1 unf=0", rp_o, ovf_o, unf_o);
      else n_pass++;
      step(OP_POPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'd4 || rp_o !== 3'd3 || ovf_o !== 1'b1)
         $display("FAIL pop_after_ovf got rs=%h rp=%0d ovf=%b required rs=4 rp=3 ovf=1", rs_seen, rp_o, ovf_o);
      else n_pass++;
   endtask

   task automatic test_empty();
      do_reset();
      step(OP_POPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'h0 || unf_o !== 1'b1 || rp_o !== 3'd0)
         $display("FAIL empty_pop got rs=%h unf=%b rp=%0d required rs=0 unf=1 rp=0", rs_seen, unf_o, rp_o);
      else n_pass++;
      step(OP_DUPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'h0 || rp_o !== 3'd0 || unf_o !== 1'b1)
         $display("FAIL empty_dupr got rs=%h rp=%0d unf=%b required rs=0 rp=0 unf=1", rs_seen, rp_o, unf_o);
      else n_pass++;
   endtask

   task automatic test_peek();
      do_reset();
      step(OP_PUSHR, 3'd0, 32'hA, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'hB, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'hC, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'hD, 16'h0, 1'b1, 1'b0);
      step(OP_ILOAD_2, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'hB) $display("FAIL iload_2 got %h required b", rs_seen);
      else n_pass++;
      step(OP_ILOAD_0, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'hD) $display("FAIL iload_0 got %h required d", rs_seen);
      else n_pass++;
      step(OP_ILOAD_3, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'hA) $display("FAIL iload_3 got %h required a", rs_seen);
      else n_pass++;
      step(OP_ILOAD, 3'd1, 32'hFFFF_FF01, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'hC) $display("FAIL iload_idx1 got %h required c", rs_seen);
      else n_pass++;
      step(OP_DUPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'hD || rp_o !== 3'd4 || unf_o !== 1'b0)
         $display("FAIL dupr got rs=%h rp=%0d unf=%b required rs=d rp=4 unf=0", rs_seen, rp_o, unf_o);
      else n_pass++;
      step(OP_ISTORE_0, 3'd0, 32'hE, 16'h0, 1'b1, 1'b0);
      step(OP_POPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'hE || rp_o !== 3'd3)
         $display("FAIL istore_pop got rs=%h rp=%0d required rs=e rp=3", rs_seen, rp_o);
      else n_pass++;
   endtask

   task automatic test_jsr_ret();
      do_reset();
      step(OP_JSR, 3'd2, 32'hDEAD_BEEF, 16'h1234, 1'b1, 1'b0);
      n_checks++;
      if (rp_o !== 3'd1) $display("FAIL jsr_rp got %0d required 1", rp_o);
      else n_pass++;
      step(OP_RET, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      n_checks++;
      if (rs_seen !== 32'h0000_1234 || rp_o !== 3'd0)
         $display("FAIL ret got rs=%h rp=%0d required rs=00001234 rp=0", rs_seen, rp_o);
      else n_pass++;
   endtask

   task automatic test_reset_enable();
      do_reset();
      step(OP_PUSHR, 3'd0, 32'h1, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'h2, 16'h0, 1'b1, 1'b0);
      step(OP_POPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      step(OP_POPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      step(OP_POPR, 3'd0, 32'h0, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'h1, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'h2, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'h3, 16'h0, 1'b1, 1'b1);
      n_checks++;
      if (rp_o !== 3'd0 || ovf_o !== 1'b0 || unf_o !== 1'b0)
         $display("FAIL reset_vs_push got rp=%0d ovf=%b unf=%b required rp=0 ovf=0 unf=0", rp_o, ovf_o, unf_o);
      else n_pass++;
      step(OP_PUSHR, 3'd0, 32'h7, 16'h0, 1'b1, 1'b0);
      step(OP_PUSHR, 3'd0, 32'h8, 16'h0, 1'b0, 1'b0);
      n_checks++;
      if (rp_o !== 3'd1) $display("FAIL push_disabled got rp=%0d required 1", rp_o);
      else n_pass++;
      step(OP_POPR, 3'd0, 32'h0, 16'h0, 1'b0, 1'b0);
      n_checks++;
      if (rs_seen !== 32'h7 || rp_o !== 3'd1)
         $display("FAIL pop_disabled got rs=%h rp=%0d required rs=7 rp=1", rs_seen, rp_o);
      else n_pass++;
   endtask

   // Reference behaviour expressed on a plain queue; back of queue is the top entry.
   task automatic model_step(input logic [7:0] c, input logic [2:0] ph, input logic [31:0] tv,
                             input logic [15:0] pv, input bit en,
                             output logic [31:0] ers, output bit has_rs);
      int k = -1;
      int n = m_stk.size();
      ers = '0; has_rs = 0;
      if (ph == 3'd0 && c == OP_PUSHR || ph == 3'd2 && c == OP_JSR) begin
         if (n < D) begin
            if (en) m_stk.push_back(c == OP_JSR ? {16'h0, pv} : tv);
         end else if (en) m_ovf = 1;
      end else if (ph == 3'd0 && (c == OP_POPR || c == OP_RET)) begin
         has_rs = 1;
         if (n == 0) begin
            if (en) m_unf = 1;
         end else begin
            ers = m_stk[n-1];
            if (en) void'(m_stk.pop_back());
         end
      end else if (ph == 3'd0 && c == OP_ISTORE_0) begin
         if (n == 0) begin
            if (en) m_unf = 1;
         end else if (en) m_stk[n-1] = tv;
      end else begin
         if (ph == 3'd0 && c == OP_DUPR) k = 0;
         if (ph == 3'd0 && c >= OP_ILOAD_0 && c <= OP_ILOAD_3) k = int'(c) - int'(OP_ILOAD_0);
         if (ph == 3'd1 && c == OP_ILOAD) k = int'(tv[1:0]);
         if (k >= 0) begin
            has_rs = 1;
            if (k < n) ers = m_stk[n-1-k];
            else if (en) m_unf = 1;
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  ops [12] = '{OP_PUSHR, OP_PUSHR, OP_JSR, OP_POPR, OP_RET, OP_DUPR,
                                OP_ILOAD_1, OP_ILOAD_2, OP_ILOAD, OP_ISTORE_0, OP_ILOAD_3, OP_NOP};
      logic [2:0]  phs [12] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
      logic [31:0] ers;
      bit          has_rs;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         int sel = $urandom_range(0, 11);
         logic [2:0]  ph = phs[sel];
         logic [31:0] tv = $urandom;
         logic [15:0] pv = 16'($urandom);
         bit en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) ph = 3'($urandom_range(0, 7));
         model_step(ops[sel], ph, tv, pv, en, ers, has_rs);
         step(ops[sel], ph, tv, pv, en, 1'b0);
         if (has_rs) begin
            n_checks++;
            if (rs_seen !== ers)
               $display("FAIL rand_rs it=%0d op=%h ph=%0d got %h required %h", i, ops[sel], ph, rs_seen, ers);
            else n_pass++;
         end
         n_checks++;
         if (rp_o !== 3'(m_stk.size()) || ovf_o !== m_ovf || unf_o !== m_unf)
            $display("FAIL rand_state it=%0d got rp=%0d ovf=%b unf=%b required rp=%0d ovf=%b unf=%b",
                     i, rp_o, ovf_o, unf_o, m_stk.size(), m_ovf, m_unf);
         else n_pass++;
         if ((m_ovf || m_unf) && $urandom_range(0, 7) == 0) do_reset();
      end
   endtask

   initial begin
      rst = 1'b1; rs_en = 1'b0; code = OP_NOP; phase = 3'd0; t = '0; pc = '0;
      test_reset();
      test_push_pop();
      test_overflow();
      test_empty();
      test_peek();
      test_jsr_ret();
      test_reset_enable();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
